// File: rtl/aes_ctr_feeder.sv
// aes_ctr_feeder: packs 32-bit plaintext words into 128-bit blocks paired with {nonce, counter}
// and hands them to the AES core over valid/ready.
module aes_ctr_feeder #(
  parameter logic [31:0] CTR_INIT = 32'h0000_0001
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [95:0]  nonce_i,
  input  logic [31:0]  din_i,
  input  logic         din_valid_i,
  input  logic         din_last_i,
  output logic         din_ready_o,
  output logic         blk_valid_o,
  input  logic         blk_ready_i,
  output logic [127:0] data_o,
  output logic [127:0] ctr_block_o,
  output logic [2:0]   blk_words_o,
  output logic         blk_last_o,
  output logic         busy_o,
  output logic         wrap_err_o
);
  typedef enum logic [1:0] {IDLE, FILL, ISSUE} state_t;
  state_t        state_q, state_d;
  logic [127:0]  data_q, data_d;
  logic [95:0]   nonce_q, nonce_d;
  logic [31:0]   ctr_q, ctr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          wrap_q, wrap_d;
  logic          acc, hs;
  assign acc = (state_q == FILL) && din_valid_i;
  assign hs  = (state_q == ISSUE) && blk_ready_i;
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      wrap_q  <= wrap_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (load_i) state_d = FILL;
    else if (acc && (din_last_i || cnt_q == 3'd3)) state_d = ISSUE;
    else if (hs) state_d = (&ctr_q || last_q) ? IDLE : FILL;
  end
  // An exhausted counter ends the stream without incrementing, so the wrapped value is never issued.
  always_comb begin
    data_d  = data_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wrap_d  = wrap_q;
    if (load_i) begin
      nonce_d = nonce_i;
      ctr_d   = CTR_INIT;
      data_d  = '0;
      cnt_d   = '0;
      last_d  = 1'b0;
      wrap_d  = 1'b0;
    end else if (acc) begin
      data_d = data_q | ({din_i, 96'd0} >> {cnt_q, 5'd0});
      cnt_d  = cnt_q + 3'd1;
      last_d = din_last_i;
    end else if (hs) begin
      if (&ctr_q) wrap_d = 1'b1;
      else begin
        ctr_d = ctr_q + 32'd1;
        if (!last_q) begin
          data_d = '0;
          cnt_d  = '0;
        end
      end
    end
  end
  always_comb begin
    din_ready_o = state_q == FILL;
    blk_valid_o = state_q == ISSUE;
    busy_o      = state_q != IDLE;
  end
  assign data_o      = data_q;
  assign ctr_block_o = {nonce_q, ctr_q};
  assign blk_words_o = cnt_q;
  assign blk_last_o  = last_q;
  assign wrap_err_o  = wrap_q;
endmodule

// File: tb/tb_aes_ctr_feeder.sv
// tb_aes_ctr_feeder: directed bench for the CTR feeder; a second instance starts near counter exhaustion.
module tb_aes_ctr_feeder;
  logic         clk_i = 1'b0, rst_n = 1'b0, load_i = 1'b0;
  logic [95:0]  nonce_i = '0;
  logic [31:0]  din_i = '0;
  logic         din_valid_i = 1'b0, din_last_i = 1'b0, blk_ready_i = 1'b0;
  logic         din_ready_o, blk_valid_o, blk_last_o, busy_o, wrap_err_o;
  logic [127:0] data_o, ctr_block_o;
  logic [2:0]   blk_words_o;
  logic         w_din_ready, w_blk_valid, w_blk_last, w_busy, w_wrap;
  logic [127:0] w_data, w_ctr;
  logic [2:0]   w_words;
  int tests = 0, fails = 0;
  localparam logic [95:0] NA = 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [95:0] NB = 96'h01234567_89ABCDEF_02468ACE;
  localparam logic [95:0] NC = 96'hCCCCCCCC_00000000_CCCCCCCC;
  localparam logic [95:0] ND = 96'hDDDDDDDD_11111111_DDDDDDDD;
  localparam logic [95:0] NE = 96'hEEEEEEEE_22222222_EEEEEEEE;
  logic [127:0] held_data;

  always #5 clk_i = ~clk_i;

  aes_ctr_feeder u_dut (
    .clk_i(clk_i), .rst_n(rst_n), .load_i(load_i), .nonce_i(nonce_i), .din_i(din_i),
    .din_valid_i(din_valid_i), .din_last_i(din_last_i), .din_ready_o(din_ready_o),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i), .data_o(data_o),
    .ctr_block_o(ctr_block_o), .blk_words_o(blk_words_o), .blk_last_o(blk_last_o),
    .busy_o(busy_o), .wrap_err_o(wrap_err_o));

  aes_ctr_feeder #(.CTR_INIT(32'hFFFF_FFFE)) u_wrap (
    .clk_i(clk_i), .rst_n(rst_n), .load_i(load_i), .nonce_i(nonce_i), .din_i(din_i),
    .din_valid_i(din_valid_i), .din_last_i(din_last_i), .din_ready_o(w_din_ready),
    .blk_valid_o(w_blk_valid), .blk_ready_i(blk_ready_i), .data_o(w_data),
    .ctr_block_o(w_ctr), .blk_words_o(w_words), .blk_last_o(w_blk_last),
    .busy_o(w_busy), .wrap_err_o(w_wrap));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [95:0] n);
    load_i = 1'b1;
    nonce_i = n;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] w, input logic l);
    int n = 0;
    din_i = w;
    din_valid_i = 1'b1;
    din_last_i = l;
    while (!din_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("push_ready", {127'd0, din_ready_o}, 128'd1);
    @(negedge clk_i);
    din_valid_i = 1'b0;
    din_last_i = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {127'd0, din_ready_o}, 128'd0);
    chk({tag, "_valid"}, {127'd0, blk_valid_o}, 128'd0);
    chk({tag, "_data"}, data_o, 128'd0);
    chk({tag, "_ctr"}, ctr_block_o, 128'd0);
    chk({tag, "_words"}, {125'd0, blk_words_o}, 128'd0);
    chk({tag, "_last"}, {127'd0, blk_last_o}, 128'd0);
    chk({tag, "_busy"}, {127'd0, busy_o}, 128'd0);
    chk({tag, "_wrap"}, {127'd0, wrap_err_o}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", {127'd0, din_ready_o}, 128'd0);
    // full block then a two-word tail: six-word message
    load(NA);
    chk("ld_ready", {127'd0, din_ready_o}, 128'd1);
    chk("ld_ctr", ctr_block_o, {NA, 32'd1});
    chk("ld_busy", {127'd0, busy_o}, 128'd1);
    blk_ready_i = 1'b1;
    push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b0);
    push(32'h33333333, 1'b0);
    push(32'h44444444, 1'b0);
    chk("b1_valid", {127'd0, blk_valid_o}, 128'd1);
    chk("b1_data", data_o, 128'h11111111_22222222_33333333_44444444);
    chk("b1_ctr", ctr_block_o, {NA, 32'd1});
    chk("b1_words", {125'd0, blk_words_o}, 128'd4);
    chk("b1_last", {127'd0, blk_last_o}, 128'd0);
    chk("b1_noready", {127'd0, din_ready_o}, 128'd0);
    push(32'h55555555, 1'b0);
    push(32'h66666666, 1'b1);
    chk("b2_valid", {127'd0, blk_valid_o}, 128'd1);
    chk("b2_data", data_o, 128'h55555555_66666666_00000000_00000000);
    chk("b2_ctr", ctr_block_o, {NA, 32'd2});
    chk("b2_words", {125'd0, blk_words_o}, 128'd2);
    chk("b2_last", {127'd0, blk_last_o}, 128'd1);
    @(negedge clk_i);
    din_valid_i = 1'b1;
    repeat (3) begin
      chk("end_busy", {127'd0, busy_o}, 128'd0);
      chk("end_ready", {127'd0, din_ready_o}, 128'd0);
      chk("end_valid", {127'd0, blk_valid_o}, 128'd0);
      @(negedge clk_i);
    end
    din_valid_i = 1'b0;
    chk("end_ctr", ctr_block_o, {NA, 32'd3});
    // core stalls for ten cycles
    blk_ready_i = 1'b0;
    load(NB);
    push(32'hA0000001, 1'b0);
    push(32'hA0000002, 1'b0);
    push(32'hA0000003, 1'b0);
    push(32'hA0000004, 1'b0);
    held_data = 128'hA0000001_A0000002_A0000003_A0000004;
    din_valid_i = 1'b1;
    repeat (10) begin
      chk("st_valid", {127'd0, blk_valid_o}, 128'd1);
      chk("st_data", data_o, held_data);
      chk("st_ctr", ctr_block_o, {NB, 32'd1});
      chk("st_ready", {127'd0, din_ready_o}, 128'd0);
      @(negedge clk_i);
    end
    din_valid_i = 1'b0;
    blk_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rel_valid", {127'd0, blk_valid_o}, 128'd0);
    chk("rel_ready", {127'd0, din_ready_o}, 128'd1);
    chk("rel_ctr", ctr_block_o, {NB, 32'd2});
    chk("rel_data", data_o, 128'd0);
    // load while a block is pending
    blk_ready_i = 1'b0;
    push(32'hB0000001, 1'b0);
    push(32'hB0000002, 1'b1);
    chk("pend_valid", {127'd0, blk_valid_o}, 128'd1);
    load(NC);
    chk("li_valid", {127'd0, blk_valid_o}, 128'd0);
    chk("li_data", data_o, 128'd0);
    chk("li_ctr", ctr_block_o, {NC, 32'd1});
    chk("li_ready", {127'd0, din_ready_o}, 128'd1);
    // load after two words of a block
    push(32'hC0000001, 1'b0);
    push(32'hC0000002, 1'b0);
    load(ND);
    chk("lf_data", data_o, 128'd0);
    chk("lf_ctr", ctr_block_o, {ND, 32'd1});
    chk("lf_words", {125'd0, blk_words_o}, 128'd0);
    push(32'hD0000001, 1'b1);
    chk("lf_bdata", data_o, {32'hD0000001, 96'd0});
    chk("lf_bwords", {125'd0, blk_words_o}, 128'd1);
    chk("lf_blast", {127'd0, blk_last_o}, 128'd1);
    chk("lf_bctr", ctr_block_o, {ND, 32'd1});
    // counter exhaustion on the second instance
    blk_ready_i = 1'b1;
    load(NE);
    chk("w_ldctr", w_ctr, {NE, 32'hFFFF_FFFE});
    push(32'h1, 1'b0);
    push(32'h2, 1'b0);
    push(32'h3, 1'b0);
    push(32'h4, 1'b0);
    chk("w_b1valid", {127'd0, w_blk_valid}, 128'd1);
    chk("w_b1ctr", w_ctr, {NE, 32'hFFFF_FFFE});
    push(32'h5, 1'b0);
    push(32'h6, 1'b0);
    push(32'h7, 1'b0);
    push(32'h8, 1'b0);
    chk("w_b2valid", {127'd0, w_blk_valid}, 128'd1);
    chk("w_b2ctr", w_ctr, {NE, 32'hFFFF_FFFF});
    chk("w_b2wrap", {127'd0, w_wrap}, 128'd0);
    @(negedge clk_i);
    din_valid_i = 1'b1;
    repeat (3) begin
      chk("w_err", {127'd0, w_wrap}, 128'd1);
      chk("w_busy", {127'd0, w_busy}, 128'd0);
      chk("w_refuse", {127'd0, w_din_ready}, 128'd0);
      chk("w_novalid", {127'd0, w_blk_valid}, 128'd0);
      chk("w_ctrheld", w_ctr, {NE, 32'hFFFF_FFFF});
      @(negedge clk_i);
    end
    din_valid_i = 1'b0;
    load(NE);
    chk("w_clr", {127'd0, w_wrap}, 128'd0);
    chk("w_reload", {127'd0, w_din_ready}, 128'd1);
    // asynchronous reset in the middle of a block
    load(NA);
    push(32'hE0000001, 1'b0);
    push(32'hE0000002, 1'b0);
    din_valid_i = 1'b1;
    din_i = 32'hE0000003;
    #2 rst_n = 1'b0;
    #1 chk_reset("arst");
    @(negedge clk_i);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_ready", {127'd0, din_ready_o}, 128'd0);
      chk("post_data", data_o, 128'd0);
      chk("post_words", {125'd0, blk_words_o}, 128'd0);
    end
    din_valid_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
